// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first; done WIDTH+1 edges after the accepted start; start is ignored while busy.
// Define SERIAL_ADDER_SUB_EN to add a sub input that selects a - b - cin (computed as a + ~b + ~cin).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic             w_sum;
    logic             w_carry;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? ~cin : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_last  = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next = S_RUN;
                    w_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // r_acc collects sum bits privately; s only changes on the edge that finishes the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
            r_carry <= w_carry;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_s    <= {w_sum, r_acc[WIDTH-1:1]};
                r_cout <= w_carry;
                r_ovf  <= r_carry ^ w_carry;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected results, one task per scenario.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic isub);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        res_t         r;
        bb     = isub ? ~ib : ib;
        cc     = isub ? ~ic : ic;
        full   = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, cc};
        r.s    = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (ia[W-1] == bb[W-1]) && (r.s[W-1] != ia[W-1]);
        return r;
    endfunction

    // Called on a negedge; the following posedge is the accept edge.
    task automatic drive_start(input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic ic, input logic isub);
        a     = ia;
        b     = ib;
        cin   = ic;
        sub   = isub;
        start = 1'b1;
        sb.push_back(model(ia, ib, ic, isub));
    endtask

    // Called on the first negedge after the accept edge (cycle 1).
    task automatic wait_done(output int cyc, output int bcnt, output bit to);
        cyc  = 1;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 4 * W) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        to = (done !== 1'b1);
    endtask

    task automatic test_reset;
        int   cyc, bcnt;
        bit   to;
        res_t got, exp;
        @(negedge clk);
        n_total++;
        if ({busy, done, s, cout, ovf} !== '0) $display("FAIL reset_state got=%h exp=0", {busy, done, s, cout, ovf});
        else n_pass++;
        rst_n = 1'b1;
        drive_start(8'h5A, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL first_start_busy got=%b exp=1", busy);
        else n_pass++;
        wait_done(cyc, bcnt, to);
        n_total++;
        if (to) $display("FAIL basic_timeout got=timeout exp=done");
        else n_pass++;
        n_total++;
        if (cyc != W + 1) $display("FAIL basic_done_edge got=%0d exp=%0d", cyc, W + 1);
        else n_pass++;
        n_total++;
        if (bcnt != W) $display("FAIL basic_busy_cycles got=%0d exp=%0d", bcnt, W);
        else n_pass++;
        got = {s, cout, ovf};
        exp = sb.pop_front();
        n_total++;
        if (got !== exp || exp !== {8'h8D, 1'b0, 1'b1}) $display("FAIL basic_result got=%h exp=%h", got, exp);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse got=%b%b exp=00", done, busy);
        else n_pass++;
    endtask

    task automatic test_add;
        logic [W-1:0] ta[4] = '{8'hFF, 8'h7F, 8'h80, 8'h12};
        logic [W-1:0] tb[4] = '{8'h00, 8'h01, 8'h80, 8'h34};
        logic         tc[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   cyc, bcnt;
        bit   to;
        res_t got, exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_start(ta[i], tb[i], tc[i], 1'b0);
            @(negedge clk);
            start = 1'b0;
            wait_done(cyc, bcnt, to);
            n_total++;
            if (cyc != W + 1) $display("FAIL add%0d_done_edge got=%0d exp=%0d", i, cyc, W + 1);
            else n_pass++;
            got = {s, cout, ovf};
            exp = sb.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL add%0d_result got=%h exp=%h", i, got, exp);
            else n_pass++;
            if (i == 0) begin
                repeat (3) @(negedge clk);
                n_total++;
                if ({s, cout, ovf} !== exp || done !== 1'b0) $display("FAIL add_hold got=%h/%b exp=%h/0", {s, cout, ovf}, done, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ignore_busy;
        int   dones = 0;
        bit   seen  = 0;
        res_t got   = '0;
        res_t exp;
        @(negedge clk);
        drive_start(8'h21, 8'h42, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 3 * W; n++) begin
            if (n == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                cin   = 1'b1;
            end
            if (n == 4) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (!seen) got = {s, cout, ovf};
                seen = 1'b1;
            end
            @(negedge clk);
        end
        exp = sb.pop_front();
        n_total++;
        if (dones != 1) $display("FAIL ignore_done_count got=%0d exp=1", dones);
        else n_pass++;
        n_total++;
        if (got !== exp) $display("FAIL ignore_result got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int   cyc, bcnt;
        bit   to;
        res_t got, exp;
        @(negedge clk);
        drive_start(8'h03, 8'h04, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        sb.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
        wait_done(cyc, bcnt, to);
        got = {s, cout, ovf};
        exp = sb.pop_front();
        n_total++;
        if (got !== exp) $display("FAIL b2b_first got=%h exp=%h", got, exp);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_no_idle got=%b%b exp=10", busy, done);
        else n_pass++;
        wait_done(cyc, bcnt, to);
        n_total++;
        if (cyc != W + 1) $display("FAIL b2b_done_edge got=%0d exp=%0d", cyc, W + 1);
        else n_pass++;
        got = {s, cout, ovf};
        exp = sb.pop_front();
        n_total++;
        if (got !== exp || got.s !== 8'h02) $display("FAIL b2b_second got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int   cyc, bcnt;
        bit   to;
        int   dones = 0;
        res_t got, exp;
        @(negedge clk);
        drive_start(8'h5A, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, s, cout, ovf} !== '0) $display("FAIL reset_mid_outputs got=%h exp=0", {busy, done, s, cout, ovf});
        else n_pass++;
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 2 * W; n++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        n_total++;
        if (dones != 0) $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
        else n_pass++;
        drive_start(8'h77, 8'h11, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt, to);
        got = {s, cout, ovf};
        exp = sb.pop_front();
        n_total++;
        if (to || got !== exp) $display("FAIL reset_mid_next got=%h exp=%h", got, exp);
        else n_pass++;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [W-1:0] ta[3] = '{8'h10, 8'h80, 8'h10};
        logic [W-1:0] tb[3] = '{8'h01, 8'h01, 8'h01};
        logic         ts[3] = '{1'b1, 1'b1, 1'b0};
        int   cyc, bcnt;
        bit   to;
        res_t got, exp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_start(ta[i], tb[i], 1'b0, ts[i]);
            @(negedge clk);
            start = 1'b0;
            wait_done(cyc, bcnt, to);
            got = {s, cout, ovf};
            exp = sb.pop_front();
            n_total++;
            if (to || got !== exp) $display("FAIL sub%0d_result got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
